// File: rtl/word_compare_seq.sv
// rtl/word_compare_seq.sv - sequenced multi-nibble equality comparator
//
// comparator_4bit: the shared 4-bit equality block, reused once per nibble.
// word_compare_seq: walks two latched words LSB nibble first through one
// comparator_4bit and reports equality plus the lowest mismatching nibble.

module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq
);

  // Pure combinational nibble equality
  assign eq = (a == b);

endmodule

module word_compare_seq #(
  parameter int NIBBLES    = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [4*NIBBLES-1:0]         a_in,
  input  logic [4*NIBBLES-1:0]         b_in,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic                         equal,
  output logic [((NIBBLES <= 2) ? 1 : $clog2(NIBBLES))-1:0] mismatch_idx
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES <= 2) ? 1 : $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            equal_q, equal_d;
  logic [IDXW-1:0] mismatch_idx_q, mismatch_idx_d;
  logic            miss_seen_q, miss_seen_d;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic            nib_eq;

  // Select the shadow nibble addressed by idx for the shared comparator
  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4];
  end

  comparator_4bit u_cmp (
    .a  (nib_a),
    .b  (nib_b),
    .eq (nib_eq)
  );

  // Next-state and result computation for the IDLE/COMPARE/DONE sequence
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    idx_d          = idx_q;
    equal_d        = equal_q;
    mismatch_idx_d = mismatch_idx_q;
    miss_seen_d    = miss_seen_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d            = a_in;
          b_d            = b_in;
          idx_d          = '0;
          equal_d        = 1'b0;
          mismatch_idx_d = '0;
          miss_seen_d    = 1'b0;
          state_d        = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (!nib_eq && (EARLY_EXIT != 0)) begin
          // First mismatch ends the scan immediately
          mismatch_idx_d = idx_q;
          equal_d        = 1'b0;
          state_d        = S_DONE;
        end else begin
          // Only the lowest mismatching nibble is remembered
          if (!nib_eq && !miss_seen_q) begin
            mismatch_idx_d = idx_q;
            miss_seen_d    = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            equal_d = nib_eq && !miss_seen_q;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state registers; asynchronous reset returns to IDLE with cleared results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      idx_q          <= '0;
      equal_q        <= 1'b0;
      mismatch_idx_q <= '0;
      miss_seen_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      idx_q          <= idx_d;
      equal_q        <= equal_d;
      mismatch_idx_q <= mismatch_idx_d;
      miss_seen_q    <= miss_seen_d;
    end
  end

  // Status outputs decoded straight from the registered state
  always_comb begin
    ready        = (state_q == S_IDLE);
    busy         = (state_q == S_COMPARE);
    done         = (state_q == S_DONE);
    equal        = equal_q;
    mismatch_idx = mismatch_idx_q;
  end

endmodule

// File: tb/tb_word_compare_seq.sv
// tb/tb_word_compare_seq.sv - testbench for word_compare_seq
module tb_word_compare_seq;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;

  // index 0: early-exit instance, index 1: full-scan instance
  logic       ready_v [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       equal_v [2];
  logic [1:0] midx_v  [2];

  int checks;
  int errors;

  word_compare_seq #(.NIBBLES(N), .EARLY_EXIT(1)) u_ee (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready        (ready_v[0]),
    .busy         (busy_v[0]),
    .done         (done_v[0]),
    .equal        (equal_v[0]),
    .mismatch_idx (midx_v[0])
  );

  word_compare_seq #(.NIBBLES(N), .EARLY_EXIT(0)) u_fs (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready        (ready_v[1]),
    .busy         (busy_v[1]),
    .done         (done_v[1]),
    .equal        (equal_v[1]),
    .mismatch_idx (midx_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit eq;
    int midx;
    int done_at;
  } exp_t;

  exp_t q_exp [2][$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: first differing nibble by arithmetic over the whole words
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input bit ee,
                                output bit eq, output int midx, output int k);
    int first;
    first = -1;
    for (int n = 0; n < N; n++)
      if (first < 0 && ((a >> (4 * n)) & 16'hF) != ((b >> (4 * n)) & 16'hF)) first = n;
    eq   = (a == b);
    midx = (first < 0) ? 0 : first;
    k    = (ee && first >= 0) ? first + 1 : N;
  endfunction

  function automatic logic [15:0] make_b(input logic [15:0] a);
    logic [15:0] r;
    case ($urandom % 4)
      0: r = a;
      1: r = a ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ready"}, int'(ready_v[i]), 1);
      chk({tag, "_busy"},  int'(busy_v[i]),  0);
      chk({tag, "_done"},  int'(done_v[i]),  0);
      chk({tag, "_equal"}, int'(equal_v[i]), 0);
      chk({tag, "_midx"},  int'(midx_v[i]),  0);
    end
  endtask

  // One comparison on both instances; caller is at a negedge with both idle
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    bit eq_m [2];
    int midx_m [2];
    int k_m [2];
    int busy_n [2];
    int done_c [2];
    int done_n [2];
    int eq_o [2];
    int mi_o [2];
    for (int i = 0; i < 2; i++) begin
      model(a, b, (i == 0), eq_m[i], midx_m[i], k_m[i]);
      busy_n[i] = 0; done_c[i] = 0; done_n[i] = 0; eq_o[i] = -1; mi_o[i] = -1;
      chk({tag, "_ready_pre"}, int'(ready_v[i]), 1);
    end
    a_in = a; b_in = b; start = 1'b1;
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (busy_v[i]) busy_n[i]++;
        if (done_v[i]) begin
          done_n[i]++;
          done_c[i] = c;
          eq_o[i] = int'(equal_v[i]);
          mi_o[i] = int'(midx_v[i]);
        end
        if (done_c[i] != 0 && c == done_c[i] + 1) begin
          chk({tag, "_hold_eq"},   int'(equal_v[i]), int'(eq_m[i]));
          chk({tag, "_hold_midx"}, int'(midx_v[i]),  midx_m[i]);
          chk({tag, "_hold_rdy"},  int'(ready_v[i]), 1);
        end
      end
      start = 1'b0;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      chk({tag, (i == 0) ? "_ee" : "_fs", "_busy_cycles"}, busy_n[i], k_m[i]);
      chk({tag, (i == 0) ? "_ee" : "_fs", "_done_cycle"},  done_c[i], k_m[i] + 1);
      chk({tag, (i == 0) ? "_ee" : "_fs", "_done_count"},  done_n[i], 1);
      chk({tag, (i == 0) ? "_ee" : "_fs", "_equal"},       eq_o[i],   int'(eq_m[i]));
      chk({tag, (i == 0) ? "_ee" : "_fs", "_midx"},        mi_o[i],   midx_m[i]);
    end
  endtask

  initial begin
    logic [15:0] ra;
    bit   eq_t;
    int   midx_t, k_t, cyc, dn;
    bit   prev_done [2];
    bit   prev_ready [2];
    exp_t e;

    checks = 0;
    errors = 0;

    // Reset held with random inputs
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    for (int c = 0; c < 4; c++) begin
      start = 1'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
      @(negedge clk);
      chk_reset_vals("rst_hold");
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_reset_vals("rst_idle");
    end

    // Directed cases
    run_op("beef",  16'hBEEF, 16'hBEEF);
    run_op("x1534", 16'h1234, 16'h1534);
    run_op("f00f",  16'hF00F, 16'h0FF0);
    run_op("top",   16'h0000, 16'hF000);
    run_op("low",   16'h1111, 16'h1112);

    // Randomized single operations
    for (int t = 0; t < 20; t++) begin
      ra = 16'($urandom);
      run_op("rand", ra, make_b(ra));
    end

    // start held high; operands change every cycle
    for (int i = 0; i < 2; i++) begin
      q_exp[i].delete();
      prev_done[i] = 1'b0;
      prev_ready[i] = 1'b0;
    end
    start = 1'b1;
    cyc = 0;
    for (int c = 0; c < 80; c++) begin
      a_in = 16'($urandom);
      b_in = make_b(a_in);
      for (int i = 0; i < 2; i++) begin
        if (ready_v[i]) begin
          model(a_in, b_in, (i == 0), eq_t, midx_t, k_t);
          e.eq = eq_t; e.midx = midx_t; e.done_at = cyc + k_t + 1;
          q_exp[i].push_back(e);
        end
      end
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (prev_done[i]) begin
          chk("b2b_done_single", int'(done_v[i]), 0);
          chk("b2b_idle_after_done", int'(ready_v[i]), 1);
        end
        if (prev_ready[i]) chk("b2b_busy_after_idle", int'(busy_v[i]), 1);
        if (done_v[i]) begin
          if (q_exp[i].size() == 0) begin
            chk("b2b_unexpected_done", 1, 0);
          end else begin
            e = q_exp[i].pop_front();
            chk("b2b_done_cycle", cyc, e.done_at);
            chk("b2b_equal", int'(equal_v[i]), int'(e.eq));
            chk("b2b_midx",  int'(midx_v[i]),  e.midx);
          end
        end
        prev_done[i]  = done_v[i];
        prev_ready[i] = ready_v[i];
      end
    end
    start = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (done_v[i] && q_exp[i].size() != 0) begin
          e = q_exp[i].pop_front();
          chk("drain_done_cycle", cyc, e.done_at);
          chk("drain_equal", int'(equal_v[i]), int'(e.eq));
          chk("drain_midx",  int'(midx_v[i]),  e.midx);
        end
      end
    end
    chk("drain_left_ee", q_exp[0].size(), 0);
    chk("drain_left_fs", q_exp[1].size(), 0);
    chk("drain_idle_ee", int'(ready_v[0]), 1);
    chk("drain_idle_fs", int'(ready_v[1]), 1);

    // Asynchronous reset while COMPARE sits at idx 1
    a_in = 16'h1234; b_in = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      if (done_v[0] || done_v[1]) dn++;
    end
    chk("async_rst_no_done", dn, 0);
    chk_reset_vals("async_rst_after");
    run_op("zero", 16'h0000, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_compare_seq.md
# word_compare_seq

Sequenced multi-nibble equality comparator. Compares two `4*NIBBLES`-bit words one nibble per cycle, LSB nibble first, through a single instance of the team's `comparator_4bit` equality block. It reports equal/not-equal and the index of the first differing nibble. A start/ready/done handshake lets an upstream controller issue comparisons without duplicating the comparator datapath per nibble.

## Interface
- `NIBBLES`, default 4: number of 4-bit nibbles per operand; legal range 2..16. Word width `W = 4*NIBBLES`.
- `EARLY_EXIT`, default 1: 1 = terminate on first mismatching nibble; 0 = always scan all nibbles.
- `IDXW`, derived `max(1, clog2(NIBBLES))`: width of the nibble index. Not user-overridable.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request a comparison; accepted only on a rising edge where `ready`=1.
- `a_in`, input, W: operand A; sampled only at acceptance.
- `b_in`, input, W: operand B; sampled only at acceptance.
- `ready`, output, 1: high exactly in IDLE.
- `busy`, output, 1: high exactly in COMPARE.
- `done`, output, 1: high for exactly one cycle (DONE state) per accepted comparison.
- `equal`, output, 1: 1 if all nibbles matched. Valid from `done` until the next acceptance.
- `mismatch_idx`, output, IDXW: index of the lowest mismatching nibble (0 = bits 3:0). It is 0 when `equal`=1. Same validity as `equal`.

## Operation
- States: IDLE, COMPARE, DONE. `ready`, `busy` and `done` are decoded from state.
- Acceptance happens in IDLE when `start`=1 at an edge:
  - latch `a_in`/`b_in` into shadow registers;
  - set `idx`=0;
  - clear `equal`, `mismatch_idx` and the internal `miss_seen` flag;
  - go to COMPARE.
- COMPARE: the comparator sees shadow nibbles `[4*idx+3:4*idx]`. At each edge:
  - Match, `idx`<NIBBLES-1: `idx`++ and stay in COMPARE.
  - Match, `idx`=NIBBLES-1: go to DONE. Set `equal` = !`miss_seen`.
  - Mismatch with EARLY_EXIT=1: `mismatch_idx`=`idx`, `equal`=0, go to DONE.
  - Mismatch with EARLY_EXIT=0: if !`miss_seen`, set `mismatch_idx`=`idx` and `miss_seen`=1. Then continue as in the match cases (last nibble → DONE with `equal`=0).
- DONE: unconditionally to IDLE on the next edge. `start` is ignored in DONE.
- `start` is ignored in COMPARE and DONE. Operand changes after acceptance have no effect.
- `idx` never exceeds NIBBLES-1. There is no wrap-around.
- Reset (`rst_n`=0, any time, including mid-COMPARE):
  - immediately forces IDLE, clears all registers, and produces no `done` pulse;
  - output values during and after reset: `ready`=1, `busy`=0, `done`=0, `equal`=0, `mismatch_idx`=0.

## Timing
- Acceptance edge E0. COMPARE occupies the cycles after E0 through E_k, where k = number of nibbles evaluated.
- Full scan: k = NIBBLES. `done`=1 in the cycle after E_NIBBLES. Latency from acceptance to `done` is NIBBLES+1 cycles.
- Early exit at nibble j: k = j+1. `done` in the cycle after E_(j+1).
- `equal`/`mismatch_idx` update on the same edge that enters DONE.
- Minimum issue interval: NIBBLES+2 cycles. `start` held high yields back-to-back operations with exactly one IDLE cycle between `done` and the next COMPARE.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `ready`=1, `busy`=0, `done`=0, `equal`=0, `mismatch_idx`=0. Release and idle: outputs unchanged.
- NIBBLES=4, `a_in`=`b_in`=16'hBEEF, one-cycle `start` → `busy` for 4 cycles. `done` in cycle 5 after acceptance, with `equal`=1, `mismatch_idx`=0. Outputs hold after `done`.
- EARLY_EXIT=1, A=16'h1234, B=16'h1534 → `busy` 3 cycles; `done` in cycle 4, `equal`=0, `mismatch_idx`=2.
- EARLY_EXIT=0, A=16'hF00F, B=16'h0FF0 → `busy` 4 cycles, `equal`=0, `mismatch_idx`=0 (first mismatch, not last).
- `start` held high; operands changed every cycle while busy → results reflect only the values sampled at each acceptance. Exactly one IDLE cycle separates operations; each `done` is exactly one cycle.
- `rst_n` pulsed low asynchronously mid-cycle while COMPARE at `idx`=1 → outputs go to reset values before the next edge, and no `done` follows. A subsequent A=B=16'h0000 compare gives `equal`=1 after the normal latency.
